// File: rtl/tube_r3_dma_ctrl.sv
// DMA request/acknowledge sequencer for Tube register 3 (PH3 drain / HP3 fill).
// Raises drq when R3 can move data, turns each dack_b handshake into one FIFO strobe.
module tube_r3_dma_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             h_rst_b,
    input  logic             cfg_start,
    input  logic             cfg_dir,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             cfg_two_byte,
    input  logic             abort,
    input  logic [1:0]       ph3_level,
    input  logic [1:0]       hp3_level,
    input  logic             dack_b,
    output logic             drq,
    output logic             r3_rd_stb,
    output logic             r3_wr_stb,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] remaining
);

    // state     | meaning
    // IDLE      | waiting for cfg_start
    // WAIT_DATA | waiting until R3 can supply/accept the next burst
    // REQ       | drq high, waiting for dack_b low (timeout counter runs)
    // RELEASE   | strobe issued, waiting for dack_b to return high
    // DONE      | one-cycle done pulse, then back to IDLE
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_REQ,
        S_RELEASE,
        S_DONE
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             dir_q, dir_nxt;
    logic             two_byte_q, two_byte_nxt;
    logic [1:0]       burst_left, burst_nxt;
    logic [TO_W-1:0]  to_cnt, to_nxt;
    logic [CNT_W-1:0] remaining_nxt;
    logic             drq_nxt, rd_nxt, wr_nxt, busy_nxt, done_nxt, err_nxt;

    logic [1:0] need, depth, hp3_free;
    logic       ready;

    assign need     = (two_byte_q && (remaining >= CNT_W'(2))) ? 2'd2 : 2'd1;
    assign depth    = two_byte_q ? 2'd2 : 2'd1;
    // Clamp so an over-reported hp3_level cannot wrap into a large free count.
    assign hp3_free = (hp3_level >= depth) ? 2'd0 : (depth - hp3_level);
    assign ready    = dir_q ? (hp3_free >= need) : (ph3_level >= need);

    always_ff @(posedge clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            state       <= S_IDLE;
            dir_q       <= 1'b0;
            two_byte_q  <= 1'b0;
            burst_left  <= 2'd0;
            to_cnt      <= '0;
            remaining   <= '0;
            drq         <= 1'b0;
            r3_rd_stb   <= 1'b0;
            r3_wr_stb   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            dir_q       <= dir_nxt;
            two_byte_q  <= two_byte_nxt;
            burst_left  <= burst_nxt;
            to_cnt      <= to_nxt;
            remaining   <= remaining_nxt;
            drq         <= drq_nxt;
            r3_rd_stb   <= rd_nxt;
            r3_wr_stb   <= wr_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            timeout_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        dir_nxt       = dir_q;
        two_byte_nxt  = two_byte_q;
        burst_nxt     = burst_left;
        to_nxt        = to_cnt;
        remaining_nxt = remaining;
        drq_nxt       = 1'b0;
        rd_nxt        = 1'b0;
        wr_nxt        = 1'b0;
        done_nxt      = 1'b0;
        err_nxt       = timeout_err;

        if (abort) begin
            state_nxt = S_IDLE;
            to_nxt    = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        err_nxt = 1'b0;
                        if (cfg_count != '0) begin
                            dir_nxt       = cfg_dir;
                            two_byte_nxt  = cfg_two_byte;
                            remaining_nxt = cfg_count;
                            state_nxt     = S_WAIT_DATA;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end
                end
                S_WAIT_DATA: begin
                    if (ready) begin
                        burst_nxt = need;
                        to_nxt    = '0;
                        drq_nxt   = 1'b1;
                        state_nxt = S_REQ;
                    end
                end
                S_REQ: begin
                    if (!dack_b) begin
                        rd_nxt    = !dir_q;
                        wr_nxt    = dir_q;
                        if (remaining != '0)
                            remaining_nxt = remaining - CNT_W'(1);
                        if (burst_left != 2'd0)
                            burst_nxt = burst_left - 2'd1;
                        to_nxt    = '0;
                        state_nxt = S_RELEASE;
                    end else if (to_cnt == TO_LAST) begin
                        err_nxt   = 1'b1;
                        to_nxt    = '0;
                        state_nxt = S_DONE;
                    end else begin
                        to_nxt  = to_cnt + TO_W'(1);
                        drq_nxt = 1'b1;
                    end
                end
                S_RELEASE: begin
                    // Inside a burst the FIFO level is not rechecked.
                    if (dack_b) begin
                        if (remaining == '0) begin
                            state_nxt = S_DONE;
                        end else if (burst_left != 2'd0) begin
                            drq_nxt   = 1'b1;
                            state_nxt = S_REQ;
                        end else begin
                            state_nxt = S_WAIT_DATA;
                        end
                    end
                end
                S_DONE: begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_tube_r3_dma_ctrl.sv
// Directed bench for tube_r3_dma_ctrl: handshakes, two-byte bursts, timeout,
// zero-count start, abort and asynchronous reset.
module tb_tube_r3_dma_ctrl;

    logic        clk = 1'b0;
    logic        h_rst_b;
    logic        cfg_start, cfg_dir, cfg_two_byte, abort;
    logic [15:0] cfg_count;
    logic [1:0]  ph3_level, hp3_level;
    logic        dack_b;
    logic        drq, r3_rd_stb, r3_wr_stb, busy, done, timeout_err;
    logic [15:0] remaining;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, drq_cnt = 0;
    int rd0, wr0, dn0, dq0, n;

    tube_r3_dma_ctrl #(.CNT_W(16), .TO_W(8), .TIMEOUT(255)) dut (
        .clk(clk), .h_rst_b(h_rst_b), .cfg_start(cfg_start), .cfg_dir(cfg_dir),
        .cfg_count(cfg_count), .cfg_two_byte(cfg_two_byte), .abort(abort),
        .ph3_level(ph3_level), .hp3_level(hp3_level), .dack_b(dack_b),
        .drq(drq), .r3_rd_stb(r3_rd_stb), .r3_wr_stb(r3_wr_stb), .busy(busy),
        .done(done), .timeout_err(timeout_err), .remaining(remaining)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (r3_rd_stb === 1'b1) rd_cnt++;
        if (r3_wr_stb === 1'b1) wr_cnt++;
        if (done === 1'b1)      done_cnt++;
        if (drq === 1'b1)       drq_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt; dq0 = drq_cnt;
    endtask

    task automatic start(input logic dir, input logic [15:0] cnt, input logic tb2);
        cfg_dir = dir; cfg_count = cnt; cfg_two_byte = tb2; cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic wait_drq(input string tag);
        n = 0;
        while (drq !== 1'b1 && n < 20) begin step(); n++; end
        check(tag, drq, 1'b1);
    endtask

    // dack_b goes low two cycles after drq is seen, held for one sampling edge.
    task automatic ack_one(input string tag, input logic dir, input logic [15:0] exp_rem);
        wait_drq({tag, "_drq"});
        step(); step();
        dack_b = 1'b0;
        step();
        check({tag, "_stb"}, dir ? r3_wr_stb : r3_rd_stb, 1'b1);
        check({tag, "_rem"}, remaining, exp_rem);
        check({tag, "_drq_low"}, drq, 1'b0);
        dack_b = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        n = 0;
        while (done !== 1'b1 && n < 20) begin step(); n++; end
        check(tag, done, 1'b1);
    endtask

    initial begin
        h_rst_b = 1'b0; cfg_start = 1'b0; cfg_dir = 1'b0; cfg_count = '0;
        cfg_two_byte = 1'b0; abort = 1'b0; ph3_level = 2'd0; hp3_level = 2'd0;
        dack_b = 1'b1;
        #12;
        check("rst_drq", drq, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", timeout_err, 1'b0);
        check("rst_rem", remaining, 16'd0);
        check("rst_stb", {r3_rd_stb, r3_wr_stb}, 2'b00);
        @(negedge clk); h_rst_b = 1'b1;
        step();

        // Drain PH3, three single-byte transfers.
        ph3_level = 2'd1;
        snap();
        start(1'b0, 16'd3, 1'b0);
        check("t1_busy", busy, 1'b1);
        check("t1_rem0", remaining, 16'd3);
        ack_one("t1_b0", 1'b0, 16'd2);
        ack_one("t1_b1", 1'b0, 16'd1);
        ack_one("t1_b2", 1'b0, 16'd0);
        wait_done("t1_done");
        step();
        check("t1_rd_cnt", rd_cnt - rd0, 3);
        check("t1_wr_cnt", wr_cnt - wr0, 0);
        check("t1_done_cnt", done_cnt - dn0, 1);
        check("t1_err", timeout_err, 1'b0);
        check("t1_busy_end", busy, 1'b0);

        // Fill HP3 in two-byte mode: 2-byte burst, then 1-byte burst.
        ph3_level = 2'd0; hp3_level = 2'd0;
        snap();
        start(1'b1, 16'd3, 1'b1);
        ack_one("t2_b0", 1'b1, 16'd2);
        hp3_level = 2'd2;              // FIFO full; the burst must continue anyway
        step();
        check("t2_burst_drq", drq, 1'b1);
        ack_one("t2_b1", 1'b1, 16'd1);
        step(); step(); step();
        check("t2_stall_drq", drq, 1'b0);
        check("t2_stall_busy", busy, 1'b1);
        hp3_level = 2'd0;
        ack_one("t2_b2", 1'b1, 16'd0);
        wait_done("t2_done");
        step();
        check("t2_wr_cnt", wr_cnt - wr0, 3);
        check("t2_rd_cnt", rd_cnt - rd0, 0);

        // No acknowledge: timeout after 255 drq cycles.
        ph3_level = 2'd2;
        snap();
        start(1'b0, 16'd2, 1'b0);
        wait_drq("t3_drq");
        n = 0;
        while (drq === 1'b1 && n < 400) begin n++; step(); end
        check("t3_drq_cycles", n, 255);
        check("t3_err", timeout_err, 1'b1);
        check("t3_rem", remaining, 16'd2);
        check("t3_done_pre", done, 1'b0);
        step();
        check("t3_done", done, 1'b1);
        check("t3_busy", busy, 1'b0);
        check("t3_rd_cnt", rd_cnt - rd0, 0);
        step();
        check("t3_err_sticky", timeout_err, 1'b1);

        // Zero-count start: done two cycles later, no drq, no strobes, error cleared.
        snap();
        start(1'b0, 16'd0, 1'b0);
        check("t4_err_clr", timeout_err, 1'b0);
        check("t4_busy", busy, 1'b1);
        check("t4_done_early", done, 1'b0);
        step();
        check("t4_done", done, 1'b1);
        step();
        check("t4_drq_cnt", drq_cnt - dq0, 0);
        check("t4_stb_cnt", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
        check("t4_done_cnt", done_cnt - dn0, 1);

        // Abort in REQ; a start during the transfer is ignored.
        ph3_level = 2'd1;
        snap();
        start(1'b0, 16'd5, 1'b0);
        wait_drq("t5_drq");
        cfg_count = 16'd9; cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("t5_rem_keep", remaining, 16'd5);
        check("t5_drq_keep", drq, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_drq", drq, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_rem", remaining, 16'd5);
        step(); step(); step();
        check("t5_no_done", done_cnt - dn0, 0);
        check("t5_no_stb", rd_cnt - rd0, 0);
        check("t5_idle_drq", drq, 1'b0);

        // dack_b held low for 4 cycles, then asynchronous reset in RELEASE.
        hp3_level = 2'd0;
        snap();
        start(1'b1, 16'd4, 1'b0);
        wait_drq("t6_drq");
        step(); step();
        dack_b = 1'b0;
        step(); step(); step(); step();
        check("t6_single_stb", wr_cnt - wr0, 1);
        check("t6_rem", remaining, 16'd3);
        check("t6_busy", busy, 1'b1);
        #2;
        h_rst_b = 1'b0;
        #1;
        check("t6_rst_drq", drq, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_stb", {r3_rd_stb, r3_wr_stb}, 2'b00);
        check("t6_rst_rem", remaining, 16'd0);
        dack_b = 1'b1;
        @(negedge clk); h_rst_b = 1'b1;
        step(); step();
        check("t6_post_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
